// File: rtl/staff_pkg.sv
// Shared types and constants for the staff overlay frame reader.
package staff_pkg;

    localparam int STAFF_PIPE_LAT = 4;
    localparam int STAFF_PIX_W = 2;
    localparam logic [1:0] STAFF_BORDER_VAL = 2'b11;

    typedef logic [STAFF_PIX_W-1:0] staff_pix_t;

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_t;

endpackage

// File: rtl/staff_dp_bram.sv
// Simple dual-port staff BRAM: write port A, two-cycle registered read port B.
module staff_dp_bram
    import staff_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW = 1
) (
    input  logic       clk,
    input  logic       we_a,
    input  logic [AW-1:0] addr_a,
    input  staff_pix_t din_a,
    input  logic [AW-1:0] addr_b,
    output staff_pix_t dout_b
);

    staff_pix_t mem [DEPTH];
    staff_pix_t rd_q;

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        rd_q <= mem[addr_b];
        dout_b <= rd_q;
    end

endmodule

// File: rtl/staff_frame_reader.sv
// Double-buffered staff overlay reader with frame-boundary bank swap.
// Define STAFF_BORDER_EN to force the window's outer ring to the border value.
module staff_frame_reader
    import staff_pkg::*;
#(
    parameter int BUF_W = 320,
    parameter int BUF_H = 90,
    parameter int SCALE_LOG2 = 2,
    parameter int WIN_X = 0,
    parameter int WIN_Y = 180,
    parameter int V_ACTIVE = 720
) (
    input  logic clk_pixel_in,
    input  logic rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0] vcount_in,
    input  logic hsync_in,
    input  logic vsync_in,
    input  logic active_draw_in,
    input  logic wr_en_in,
    input  logic [$clog2(BUF_W*BUF_H)-1:0] wr_addr_in,
    input  logic [1:0] wr_data_in,
    input  logic swap_req_in,
    output logic swap_ack_out,
    output logic front_bank_out,
    output logic [1:0] staff_pixel_out,
    output logic bg_out,
    output logic hsync_out,
    output logic vsync_out,
    output logic active_draw_out
);

    localparam int PIX_N = BUF_W * BUF_H;
    localparam int AW = $clog2(PIX_N);
    localparam int BW = $clog2(2 * PIX_N);
    localparam int WIN_W = BUF_W << SCALE_LOG2;
    localparam int WIN_H = BUF_H << SCALE_LOG2;
    localparam int LAT = STAFF_PIPE_LAT - 1;

    int h_i;
    int v_i;
    logic in_win;
    logic boundary;
    logic [AW-1:0] bx;
    logic [AW-1:0] by;
    logic [AW-1:0] rd_addr;

    assign h_i = int'(hcount_in);
    assign v_i = int'(vcount_in);
    assign in_win = (h_i >= WIN_X) && (h_i < WIN_X + WIN_W) &&
                    (v_i >= WIN_Y) && (v_i < WIN_Y + WIN_H);
    assign bx = AW'((h_i - WIN_X) >>> SCALE_LOG2);
    assign by = AW'((v_i - WIN_Y) >>> SCALE_LOG2);
    assign rd_addr = by * AW'(BUF_W) + bx;
    assign boundary = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));

    swap_state_t state_q;
    swap_state_t state_d;
    logic front_q;
    logic take;

    // The cycle carrying the ack may still see the old request level.
    always_comb begin
        state_d = state_q;
        take = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (swap_req_in && !swap_ack_out) begin
                    if (boundary) begin
                        take = 1'b1;
                    end else begin
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (boundary) begin
                    take = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            front_q <= 1'b0;
            swap_ack_out <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_q ^ take;
            swap_ack_out <= take;
        end
    end

    assign front_bank_out = front_q;

    logic wr_ok;
    logic [BW-1:0] wr_lin;
    logic [AW-1:0] addr_q;
    logic bank_q;
    logic [BW-1:0] rd_lin;
    staff_pix_t bram_dout;
    staff_pix_t pix_sel;

    assign wr_ok = wr_en_in && (int'(wr_addr_in) < PIX_N);
    assign wr_lin = front_q ? BW'(wr_addr_in) : BW'(wr_addr_in) + BW'(PIX_N);
    assign rd_lin = bank_q ? BW'(addr_q) + BW'(PIX_N) : BW'(addr_q);

    staff_dp_bram #(
        .DEPTH(2 * PIX_N),
        .AW(BW)
    ) u_bram (
        .clk(clk_pixel_in),
        .we_a(wr_ok),
        .addr_a(wr_lin),
        .din_a(wr_data_in),
        .addr_b(rd_lin),
        .dout_b(bram_dout)
    );

    logic [LAT-1:0] hs_d;
    logic [LAT-1:0] vs_d;
    logic [LAT-1:0] act_d;
    logic [LAT-1:0] win_d;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q <= '0;
            bank_q <= 1'b0;
            hs_d <= '0;
            vs_d <= '0;
            act_d <= '0;
            win_d <= '0;
        end else begin
            addr_q <= rd_addr;
            bank_q <= front_q;
            hs_d <= {hs_d[LAT-2:0], hsync_in};
            vs_d <= {vs_d[LAT-2:0], vsync_in};
            act_d <= {act_d[LAT-2:0], active_draw_in};
            win_d <= {win_d[LAT-2:0], in_win};
        end
    end

`ifdef STAFF_BORDER_EN
    logic on_edge;
    logic [LAT-1:0] brd_d;

    assign on_edge = (h_i == WIN_X) || (h_i == WIN_X + WIN_W - 1) ||
                     (v_i == WIN_Y) || (v_i == WIN_Y + WIN_H - 1);

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            brd_d <= '0;
        end else begin
            brd_d <= {brd_d[LAT-2:0], on_edge};
        end
    end

    assign pix_sel = brd_d[LAT-1] ? STAFF_BORDER_VAL : bram_dout;
`else
    assign pix_sel = bram_dout;
`endif

    logic bg_d;

    assign bg_d = win_d[LAT-1] & act_d[LAT-1];

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bg_out <= 1'b0;
            staff_pixel_out <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            active_draw_out <= 1'b0;
        end else begin
            bg_out <= bg_d;
            staff_pixel_out <= bg_d ? pix_sel : '0;
            hsync_out <= hs_d[LAT-1];
            vsync_out <= vs_d[LAT-1];
            active_draw_out <= act_d[LAT-1];
        end
    end

endmodule

// File: tb/tb_staff_frame_reader.sv
// Directed bench for staff_frame_reader: latency, addressing, window, swaps.
module tb_staff_frame_reader;

    logic clk;
    logic rst_n;
    logic [10:0] hcount;
    logic [9:0] vcount;
    logic hsync;
    logic vsync;
    logic act;
    logic wr_en;
    logic [14:0] wr_addr;
    logic [1:0] wr_data;
    logic req;
    logic ack;
    logic fb;
    logic [1:0] pix;
    logic bg;
    logic hs_o;
    logic vs_o;
    logic act_o;

    int checks = 0;
    int errors = 0;

`ifdef STAFF_BORDER_EN
    localparam bit BRD = 1'b1;
`else
    localparam bit BRD = 1'b0;
`endif

    staff_frame_reader dut (
        .clk_pixel_in(clk),
        .rst_n_in(rst_n),
        .hcount_in(hcount),
        .vcount_in(vcount),
        .hsync_in(hsync),
        .vsync_in(vsync),
        .active_draw_in(act),
        .wr_en_in(wr_en),
        .wr_addr_in(wr_addr),
        .wr_data_in(wr_data),
        .swap_req_in(req),
        .swap_ack_out(ack),
        .front_bank_out(fb),
        .staff_pixel_out(pix),
        .bg_out(bg),
        .hsync_out(hs_o),
        .vsync_out(vs_o),
        .active_draw_out(act_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got,
                         input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int h, input int v, input logic a);
        hcount = 11'(h);
        vcount = 10'(v);
        act = a;
        hsync = 1'b0;
        vsync = 1'b0;
    endtask

    task automatic idle();
        set_pix(0, 0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [1:0] d);
        wr_en = 1'b1;
        wr_addr = 15'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [1:0] ep(input int h, input int v,
                                      input logic [1:0] d);
        if (BRD && (h == 0 || h == 1279 || v == 180 || v == 539))
            return 2'b11;
        return d;
    endfunction

    task automatic probe(input string tag, input int h, input int v,
                         input logic a, input logic ebg,
                         input logic [1:0] epx);
        set_pix(h, v, a);
        tick();
        idle();
        tick();
        tick();
        tick();
        check({tag, "_bg"}, {1'b0, bg}, {1'b0, ebg});
        check({tag, "_px"}, pix, epx);
    endtask

    task automatic boundary_swap(input string tag, input logic efb);
        set_pix(0, 720, 1'b0);
        tick();
        check({tag, "_ack"}, {1'b0, ack}, 2'd1);
        check({tag, "_fb"}, {1'b0, fb}, {1'b0, efb});
        req = 1'b0;
        wr_en = 1'b0;
        idle();
        tick();
        check({tag, "_ack_end"}, {1'b0, ack}, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        req = 1'b0;
        set_pix(500, 200, 1'b1);
        hsync = 1'b1;
        tick();
        tick();
        check("rst_bg", {1'b0, bg}, 2'd0);
        check("rst_px", pix, 2'd0);
        check("rst_hs", {1'b0, hs_o}, 2'd0);
        check("rst_fb", {1'b0, fb}, 2'd0);
        check("rst_ack", {1'b0, ack}, 2'd0);

        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("lat3_bg", {1'b0, bg}, 2'd0);
        tick();
        check("lat4_bg", {1'b0, bg}, 2'd1);
        check("lat4_hs", {1'b0, hs_o}, 2'd1);
        check("lat4_act", {1'b0, act_o}, 2'd1);
        idle();

        wr(0, 2'b10);
        wr(1, 2'b01);
        wr(320, 2'b11);
        wr(319, 2'b01);
        wr(5, 2'b01);

        req = 1'b1;
        set_pix(500, 700, 1'b1);
        tick();
        check("pend_ack", {1'b0, ack}, 2'd0);
        check("pend_fb", {1'b0, fb}, 2'd0);
        boundary_swap("swap1", 1'b1);

        probe("p0_180", 0, 180, 1'b1, 1'b1, ep(0, 180, 2'b10));
        probe("p7_183", 7, 183, 1'b1, 1'b1, ep(7, 183, 2'b01));
        probe("p3_183", 3, 183, 1'b1, 1'b1, ep(3, 183, 2'b10));
        probe("p0_184", 0, 184, 1'b1, 1'b1, ep(0, 184, 2'b11));
        probe("p1279", 1279, 180, 1'b1, 1'b1, ep(1279, 180, 2'b01));
        probe("p20_182", 20, 182, 1'b1, 1'b1, ep(20, 182, 2'b01));
        probe("p0_540", 0, 540, 1'b1, 1'b0, 2'b00);
        probe("p1280", 1280, 180, 1'b1, 1'b0, 2'b00);
        probe("noact", 8, 184, 1'b0, 1'b0, 2'b00);

        wr(28800, 2'b01);
        probe("oor", 3, 183, 1'b1, 1'b1, ep(3, 183, 2'b10));

        req = 1'b1;
        wr_en = 1'b1;
        wr_addr = 15'd5;
        wr_data = 2'b11;
        boundary_swap("swap2", 1'b0);
        probe("swapwr", 20, 182, 1'b1, 1'b1, ep(20, 182, 2'b11));

        req = 1'b1;
        set_pix(1, 720, 1'b0);
        tick();
        check("defer_ack1", {1'b0, ack}, 2'd0);
        req = 1'b0;
        set_pix(2, 720, 1'b0);
        tick();
        check("defer_ack2", {1'b0, ack}, 2'd0);
        check("defer_fb", {1'b0, fb}, 2'd0);
        boundary_swap("swap3", 1'b1);
        probe("bank1_again", 3, 183, 1'b1, 1'b1, ep(3, 183, 2'b10));

        set_pix(3, 183, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        idle();
        #1;
        check("mid_rst_bg", {1'b0, bg}, 2'd0);
        check("mid_rst_fb", {1'b0, fb}, 2'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("flush_bg", {1'b0, bg}, 2'd0);
        check("flush_px", pix, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
